// File: rtl/speicher_schnittstelle_pkg.sv
// Shared types and constants for the CPU memory interface.
package speicher_schnittstelle_pkg;

  typedef enum logic [2:0] {
    LEERLAUF,
    INSTR_LESEN,
    DATEN_LESEN,
    DATEN_SCHREIBEN,
    FERTIG
  } zustand_t;

  typedef enum logic [1:0] {
    ART_INSTR,
    ART_LESEN,
    ART_SCHREIBEN
  } zugriffsart_t;

  localparam logic [31:0] FEHLER_WORT_STANDARD = 32'hDEADBEEF;

  // True when no address bit at or above the memory width is set.
  function automatic logic adresseGueltig(input logic [31:0] adresse, input int unsigned breite);
    return (adresse >> breite) == 32'd0;
  endfunction

endpackage

// File: rtl/speicher_schnittstelle_waechter.sv
// Ready-timeout counter: armed by Start, disarmed by Stopp, flags expiry.
module zugriffs_waechter #(
  parameter int unsigned TIMEOUT_ZYKLEN = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Stopp,
  output logic Abgelaufen
);

  localparam int unsigned ZW = (TIMEOUT_ZYKLEN > 1) ? $clog2(TIMEOUT_ZYKLEN + 1) : 1;

  logic [ZW-1:0] zaehler;
  logic          aktiv;

  // Count access cycles while armed; Start restarts from zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zaehler <= '0;
      aktiv   <= 1'b0;
    end else if (Start) begin
      zaehler <= '0;
      aktiv   <= 1'b1;
    end else if (Stopp) begin
      aktiv   <= 1'b0;
    end else if (aktiv) begin
      zaehler <= zaehler + 1'b1;
    end
  end

  // Expiry is flagged on the cycle whose closing edge would be the TIMEOUT_ZYKLEN-th.
  generate
    if (TIMEOUT_ZYKLEN == 0) begin : g_aus
      assign Abgelaufen = 1'b0;
    end else begin : g_ein
      assign Abgelaufen = aktiv && (zaehler == ZW'(TIMEOUT_ZYKLEN - 1));
    end
  endgenerate

endmodule

// File: rtl/speicher_schnittstelle.sv
// Arbitrates CPU fetch/load/store requests onto one single-port memory with ready handshake.
module speicher_schnittstelle
  import speicher_schnittstelle_pkg::*;
#(
  parameter int unsigned ADRESS_BREITE  = 16,
  parameter int unsigned TIMEOUT_ZYKLEN = 255,
  parameter logic [31:0] FEHLER_WORT    = FEHLER_WORT_STANDARD
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              InstruktionAdresse,
  input  logic                     LeseInstruktion,
  input  logic [31:0]              DatenAdresse,
  input  logic [31:0]              DatenRaus,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  output logic [31:0]              Instruktion,
  output logic [31:0]              DatenRein,
  output logic                     InstruktionGeladen,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic                     ZugriffsFehler,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [31:0]              SpeicherSchreibDaten,
  output logic                     SpeicherLesen,
  output logic                     SpeicherSchreiben,
  input  logic [31:0]              SpeicherLeseDaten,
  input  logic                     SpeicherBereit
);

  zustand_t     zustand, zustandNaechst;
  zugriffsart_t art, neueArt;
  logic [31:0]  neueAdresse;
  logic [31:0]  leseWort;
  logic         anfrage, adresseOk, zugriff, ende;
  logic         fehler, start, stopp, abgelaufen;

  zugriffs_waechter #(.TIMEOUT_ZYKLEN(TIMEOUT_ZYKLEN)) uWaechter (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (start),
    .Stopp      (stopp),
    .Abgelaufen (abgelaufen)
  );

  // Request priority: store over load over fetch.
  always_comb begin
    neueArt     = ART_INSTR;
    neueAdresse = InstruktionAdresse;
    if (SchreibeDaten) begin
      neueArt     = ART_SCHREIBEN;
      neueAdresse = DatenAdresse;
    end else if (LeseDaten) begin
      neueArt     = ART_LESEN;
      neueAdresse = DatenAdresse;
    end
  end

  assign anfrage   = SchreibeDaten | LeseDaten | LeseInstruktion;
  assign adresseOk = adresseGueltig(neueAdresse, ADRESS_BREITE);
  assign zugriff   = (zustand == INSTR_LESEN) || (zustand == DATEN_LESEN) ||
                     (zustand == DATEN_SCHREIBEN);
  assign ende      = zugriff && (SpeicherBereit || abgelaufen);
  assign leseWort  = SpeicherBereit ? SpeicherLeseDaten : FEHLER_WORT;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) zustand <= LEERLAUF;
    else       zustand <= zustandNaechst;
  end

  // Next-state logic and timeout arming.
  always_comb begin
    zustandNaechst = zustand;
    start          = 1'b0;
    stopp          = 1'b0;
    case (zustand)
      LEERLAUF: begin
        if (anfrage) begin
          if (!adresseOk) begin
            zustandNaechst = FERTIG;
          end else begin
            start = 1'b1;
            case (neueArt)
              ART_SCHREIBEN: zustandNaechst = DATEN_SCHREIBEN;
              ART_LESEN:     zustandNaechst = DATEN_LESEN;
              default:       zustandNaechst = INSTR_LESEN;
            endcase
          end
        end
      end
      INSTR_LESEN, DATEN_LESEN, DATEN_SCHREIBEN: begin
        if (SpeicherBereit || abgelaufen) begin
          zustandNaechst = FERTIG;
          stopp          = 1'b1;
        end
      end
      FERTIG:  zustandNaechst = LEERLAUF;
      default: zustandNaechst = LEERLAUF;
    endcase
  end

  // Capture request at acceptance; latch read result or error word when the access ends.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      art                  <= ART_INSTR;
      fehler               <= 1'b0;
      Instruktion          <= '0;
      DatenRein            <= '0;
      SpeicherAdresse      <= '0;
      SpeicherSchreibDaten <= '0;
    end else if ((zustand == LEERLAUF) && anfrage) begin
      art             <= neueArt;
      fehler          <= !adresseOk;
      SpeicherAdresse <= neueAdresse[ADRESS_BREITE-1:0];
      if (neueArt == ART_SCHREIBEN) SpeicherSchreibDaten <= DatenRaus;
      if (!adresseOk) begin
        if (neueArt == ART_INSTR) Instruktion <= FEHLER_WORT;
        if (neueArt == ART_LESEN) DatenRein   <= FEHLER_WORT;
      end
    end else if (ende) begin
      fehler <= !SpeicherBereit;
      if (art == ART_INSTR) Instruktion <= leseWort;
      if (art == ART_LESEN) DatenRein   <= leseWort;
    end
  end

  assign SpeicherLesen      = (zustand == INSTR_LESEN) || (zustand == DATEN_LESEN);
  assign SpeicherSchreiben  = (zustand == DATEN_SCHREIBEN);
  assign InstruktionGeladen = (zustand == FERTIG) && (art == ART_INSTR);
  assign DatenGeladen       = (zustand == FERTIG) && (art == ART_LESEN);
  assign DatenGespeichert   = (zustand == FERTIG) && (art == ART_SCHREIBEN);
  assign ZugriffsFehler     = (zustand == FERTIG) && fehler;

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// Self-checking bench: vector table, memory model with programmable latency, completion scoreboard.
module tb_speicher_schnittstelle;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] InstruktionAdresse = '0, DatenAdresse = '0, DatenRaus = '0;
  logic        LeseInstruktion = 1'b0, LeseDaten = 1'b0, SchreibeDaten = 1'b0;
  logic [31:0] Instruktion, DatenRein;
  logic        InstruktionGeladen, DatenGeladen, DatenGespeichert, ZugriffsFehler;
  logic [15:0] SpeicherAdresse;
  logic [31:0] SpeicherSchreibDaten;
  logic        SpeicherLesen, SpeicherSchreiben;
  logic [31:0] SpeicherLeseDaten = '0;
  logic        SpeicherBereit = 1'b0;

  speicher_schnittstelle #(
    .ADRESS_BREITE  (16),
    .TIMEOUT_ZYKLEN (4),
    .FEHLER_WORT    (32'hDEADBEEF)
  ) dut (
    .Clock                (Clock),
    .Reset                (Reset),
    .InstruktionAdresse   (InstruktionAdresse),
    .LeseInstruktion      (LeseInstruktion),
    .DatenAdresse         (DatenAdresse),
    .DatenRaus            (DatenRaus),
    .LeseDaten            (LeseDaten),
    .SchreibeDaten        (SchreibeDaten),
    .Instruktion          (Instruktion),
    .DatenRein            (DatenRein),
    .InstruktionGeladen   (InstruktionGeladen),
    .DatenGeladen         (DatenGeladen),
    .DatenGespeichert     (DatenGespeichert),
    .ZugriffsFehler       (ZugriffsFehler),
    .SpeicherAdresse      (SpeicherAdresse),
    .SpeicherSchreibDaten (SpeicherSchreibDaten),
    .SpeicherLesen        (SpeicherLesen),
    .SpeicherSchreiben    (SpeicherSchreiben),
    .SpeicherLeseDaten    (SpeicherLeseDaten),
    .SpeicherBereit       (SpeicherBereit)
  );

  always #5 Clock = ~Clock;

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          lat;
    logic [31:0] wort;
    logic        fehler;
    int          strobes;
  } vek_t;

  int checks = 0;
  int failures = 0;
  vek_t erwartet[$];
  logic [31:0] modelInstr = '0, modelDaten = '0;

  // Memory model
  logic [31:0] mem [int];
  int          latenz = 1;
  int          memZyklus = 0;
  int          schreibAnzahl = 0;
  logic [15:0] letzteSchreibAdr = '0;
  logic [31:0] letzteSchreibDat = '0;

  task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
    checks++;
    if (ist !== soll) begin
      failures++;
      $display("FAIL %s: ist=%h soll=%h", name, ist, soll);
    end
  endtask

  function automatic logic puls(input int kind);
    case (kind)
      0:       return InstruktionGeladen;
      1:       return DatenGeladen;
      default: return DatenGespeichert;
    endcase
  endfunction

  // Memory answers on the latenz-th strobe cycle (latenz=0: never answers).
  always @(negedge Clock) begin
    if (SpeicherLesen || SpeicherSchreiben) begin
      memZyklus = memZyklus + 1;
      if (latenz != 0 && memZyklus == latenz) begin
        SpeicherBereit    = 1'b1;
        SpeicherLeseDaten = mem.exists(int'(SpeicherAdresse)) ? mem[int'(SpeicherAdresse)] : 32'h0;
        if (SpeicherSchreiben) begin
          mem[int'(SpeicherAdresse)] = SpeicherSchreibDaten;
          schreibAnzahl    = schreibAnzahl + 1;
          letzteSchreibAdr = SpeicherAdresse;
          letzteSchreibDat = SpeicherSchreibDaten;
        end
      end else begin
        SpeicherBereit    = 1'b0;
        SpeicherLeseDaten = 32'h0;
      end
    end else begin
      memZyklus      = 0;
      SpeicherBereit = 1'b0;
    end
  end

  // Completion monitor / scoreboard
  int strobeZ = 0;
  int schreibStand = 0;
  always @(negedge Clock) begin
    int pulse;
    int got;
    vek_t e;
    if (Reset) begin
      strobeZ = 0;
      schreibStand = schreibAnzahl;
    end else begin
      if (SpeicherLesen || SpeicherSchreiben) strobeZ = strobeZ + 1;
      if (SpeicherLesen && SpeicherSchreiben) pruefe("beide_strobes", 32'd1, 32'd0);
      pulse = int'(InstruktionGeladen) + int'(DatenGeladen) + int'(DatenGespeichert);
      if (pulse > 1) begin
        pruefe("mehrere_pulse", pulse, 32'd1);
      end else if (pulse == 1) begin
        got = InstruktionGeladen ? 0 : (DatenGeladen ? 1 : 2);
        if (erwartet.size() == 0) begin
          pruefe("unerwarteter_puls", got, 32'hFFFFFFFF);
        end else begin
          e = erwartet.pop_front();
          pruefe("puls_art", got, e.kind);
          pruefe("zugriffsfehler", ZugriffsFehler, e.fehler);
          pruefe("strobe_zyklen", strobeZ, e.strobes);
          if (e.kind == 0) modelInstr = e.wort;
          if (e.kind == 1) modelDaten = e.wort;
          pruefe("instruktion", Instruktion, modelInstr);
          pruefe("daten_rein", DatenRein, modelDaten);
          if (e.kind == 2) begin
            pruefe("schreib_anzahl", schreibAnzahl - schreibStand, e.fehler ? 0 : 1);
            if (!e.fehler) begin
              pruefe("schreib_adr", letzteSchreibAdr, e.adr[15:0]);
              pruefe("schreib_dat", letzteSchreibDat, e.wdat);
            end
          end
        end
        strobeZ = 0;
        schreibStand = schreibAnzahl;
      end else if (ZugriffsFehler) begin
        pruefe("fehler_ohne_puls", 32'd1, 32'd0);
      end
    end
  end

  task automatic treibe(input vek_t v);
    case (v.kind)
      0: begin LeseInstruktion = 1'b1; InstruktionAdresse = v.adr; end
      1: begin LeseDaten = 1'b1; DatenAdresse = v.adr; end
      default: begin SchreibeDaten = 1'b1; DatenAdresse = v.adr; DatenRaus = v.wdat; end
    endcase
  endtask

  task automatic loese(input int kind);
    case (kind)
      0: LeseInstruktion = 1'b0;
      1: LeseDaten = 1'b0;
      default: SchreibeDaten = 1'b0;
    endcase
  endtask

  task automatic warteAuf(input int kind, input bit verwirren);
    bit ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge Clock);
      if (puls(kind)) ok = 1;
      else if (n == 0 && verwirren) begin
        // inputs changed after acceptance must not affect the access
        InstruktionAdresse = InstruktionAdresse ^ 32'h0000_0F00;
        DatenAdresse       = DatenAdresse ^ 32'h0000_0F00;
        DatenRaus          = ~DatenRaus;
      end
    end
    if (!ok) pruefe("fertig_zeitlimit", 32'd0, 32'd1);
    loese(kind);
  endtask

  task automatic transaktion(input vek_t v);
    @(negedge Clock);
    latenz = v.lat;
    treibe(v);
    erwartet.push_back(v);
    warteAuf(v.kind, 1'b1);
  endtask

  vek_t tabelle[11];
  vek_t v;

  initial begin
    mem[32'h10]   = 32'h12345678;
    mem[32'hFFFF] = 32'h0BADF00D;
    tabelle[0]  = '{0, 32'h0000_0010, 32'h0,        3, 32'h12345678, 1'b0, 3};
    tabelle[1]  = '{2, 32'h0000_0020, 32'hCAFEF00D, 1, 32'h0,        1'b0, 1};
    tabelle[2]  = '{1, 32'h0000_0020, 32'h0,        2, 32'hCAFEF00D, 1'b0, 2};
    tabelle[3]  = '{1, 32'h0001_0000, 32'h0,        1, 32'hDEADBEEF, 1'b1, 0};
    tabelle[4]  = '{0, 32'h8000_0010, 32'h0,        1, 32'hDEADBEEF, 1'b1, 0};
    tabelle[5]  = '{2, 32'h0002_0020, 32'h11111111, 1, 32'h0,        1'b1, 0};
    tabelle[6]  = '{1, 32'h0000_0020, 32'h0,        1, 32'hCAFEF00D, 1'b0, 1};
    tabelle[7]  = '{1, 32'h0000_0044, 32'h0,        0, 32'hDEADBEEF, 1'b1, 4};
    tabelle[8]  = '{0, 32'h0000_0010, 32'h0,        4, 32'h12345678, 1'b0, 4};
    tabelle[9]  = '{0, 32'h0000_0044, 32'h0,        0, 32'hDEADBEEF, 1'b1, 4};
    tabelle[10] = '{1, 32'h0000_FFFF, 32'h0,        1, 32'h0BADF00D, 1'b0, 1};

    // reset state
    repeat (2) @(negedge Clock);
    pruefe("reset_instruktion", Instruktion, 32'h0);
    pruefe("reset_daten_rein", DatenRein, 32'h0);
    pruefe("reset_pulse", {29'h0, InstruktionGeladen, DatenGeladen, DatenGespeichert}, 32'h0);
    pruefe("reset_strobes", {30'h0, SpeicherLesen, SpeicherSchreiben}, 32'h0);
    pruefe("reset_fehler", ZugriffsFehler, 1'b0);
    pruefe("reset_adresse", SpeicherAdresse, 16'h0);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) transaktion(tabelle[i]);

    // simultaneous requests: store, then load, then fetch
    @(negedge Clock);
    latenz = 1;
    InstruktionAdresse = 32'h10;
    DatenAdresse = 32'h30;
    DatenRaus = 32'h5A5AA5A5;
    LeseInstruktion = 1'b1; LeseDaten = 1'b1; SchreibeDaten = 1'b1;
    v = '{2, 32'h30, 32'h5A5AA5A5, 1, 32'h0, 1'b0, 1};        erwartet.push_back(v);
    v = '{1, 32'h30, 32'h0,        1, 32'h5A5AA5A5, 1'b0, 1}; erwartet.push_back(v);
    v = '{0, 32'h10, 32'h0,        1, 32'h12345678, 1'b0, 1}; erwartet.push_back(v);
    warteAuf(2, 1'b0);
    warteAuf(1, 1'b0);
    warteAuf(0, 1'b0);

    // reset in the middle of a read whose ready is already pending
    @(negedge Clock);
    latenz = 2;
    InstruktionAdresse = 32'h10;
    LeseInstruktion = 1'b1;
    repeat (2) @(negedge Clock);
    #1 Reset = 1'b1;
    #1;
    pruefe("abbruch_strobe", SpeicherLesen, 1'b0);
    pruefe("abbruch_instruktion", Instruktion, 32'h0);
    pruefe("abbruch_daten_rein", DatenRein, 32'h0);
    pruefe("abbruch_schreibdaten", SpeicherSchreibDaten, 32'h0);
    pruefe("abbruch_puls", InstruktionGeladen, 1'b0);
    LeseInstruktion = 1'b0;
    modelInstr = '0;
    modelDaten = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    v = '{0, 32'h10, 32'h0, 3, 32'h12345678, 1'b0, 3};
    transaktion(v);

    repeat (3) @(negedge Clock);
    pruefe("scoreboard_leer", erwartet.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globales_zeitlimit: ist=abgelaufen soll=fertig");
    $fatal(1);
  end

endmodule
